// File: rtl/axis_bram_playback_ctrl.sv
// ============================================================================
// axis_bram_playback_ctrl
//
// Sequencer for a stop-mode AXIS BRAM reader. It loads the reader's end
// address, releases the reader from reset on a trigger, and counts completed
// bursts by watching the reader's tlast handshake. Between bursts it holds
// the reader in reset for a programmable gap, then re-arms it. It repeats
// this for a programmable number of bursts, or forever when repeat is 0.
// The reader's AXIS output goes straight on to the DAC/DMA path; this block
// only taps the handshake signals.
//
// State table:
//   state  | meaning
//   IDLE   | reader held in reset, waiting for a trigger rising edge
//   ARM    | one cycle: reader still in reset, end address presented
//   RUN    | reader released, counting tlast handshakes
//   GAP    | reader held in reset for the latched gap cycles
//   DONE   | one cycle: completion pulse, reader back in reset
//
// Ports:
//   aclk         clock
//   aresetn      asynchronous active-low reset
//   cfg_last     end address; one burst covers addresses 0..cfg_last
//   cfg_repeat   bursts per run; 0 runs until stop
//   cfg_gap      idle cycles between bursts
//   trg          start trigger, rising-edge sensitive
//   stop         abort, level sampled every cycle
//   mon_tvalid   tap of reader m_axis_tvalid
//   mon_tready   tap of reader m_axis_tready
//   mon_tlast    tap of reader m_axis_tlast
//   rdr_aresetn  active-low reset to the reader
//   rdr_cfg      end address to the reader cfg_data
//   sts_busy     high in any state other than IDLE
//   sts_count    bursts completed in the current/last run
//   done         one-cycle pulse on normal completion
// ============================================================================
module axis_bram_playback_ctrl #(
    parameter int BRAM_ADDR_WIDTH = 10,
    parameter int REPEAT_WIDTH    = 16,
    parameter int GAP_WIDTH       = 16
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [BRAM_ADDR_WIDTH-1:0] cfg_last,
    input  logic [REPEAT_WIDTH-1:0]    cfg_repeat,
    input  logic [GAP_WIDTH-1:0]       cfg_gap,
    input  logic                       trg,
    input  logic                       stop,
    input  logic                       mon_tvalid,
    input  logic                       mon_tready,
    input  logic                       mon_tlast,
    output logic                       rdr_aresetn,
    output logic [BRAM_ADDR_WIDTH-1:0] rdr_cfg,
    output logic                       sts_busy,
    output logic [REPEAT_WIDTH-1:0]    sts_count,
    output logic                       done
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARM  = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]              state;
    logic [2:0]              state_nxt;
    logic                    trg_prev;
    logic                    start_evt;
    logic                    tlast_hs;
    logic [REPEAT_WIDTH-1:0] repeat_q;
    logic [GAP_WIDTH-1:0]    gap_q;
    logic [GAP_WIDTH-1:0]    gap_cnt;
    logic [REPEAT_WIDTH-1:0] count_inc;

    assign start_evt = trg & ~trg_prev;
    assign tlast_hs  = mon_tvalid & mon_tready & mon_tlast;
    assign count_inc = sts_count + REPEAT_WIDTH'(1);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_evt && (cfg_last != '0)) begin
                    state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                state_nxt = stop ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                // stop wins over the burst transition, but the count below
                // still takes a coincident tlast handshake.
                if (stop) begin
                    state_nxt = S_IDLE;
                end else if (tlast_hs) begin
                    if ((repeat_q != '0) && (count_inc == repeat_q)) begin
                        state_nxt = S_DONE;
                    end else if (gap_q != '0) begin
                        state_nxt = S_GAP;
                    end else begin
                        state_nxt = S_ARM;
                    end
                end
            end
            S_GAP: begin
                if (stop) begin
                    state_nxt = S_IDLE;
                end else if (gap_cnt <= GAP_WIDTH'(1)) begin
                    state_nxt = S_ARM;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so that they line up with
    // the state register: the reader leaves reset exactly when RUN begins.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= S_IDLE;
            trg_prev    <= 1'b1;
            repeat_q    <= '0;
            gap_q       <= '0;
            gap_cnt     <= '0;
            rdr_aresetn <= 1'b0;
            rdr_cfg     <= '0;
            sts_busy    <= 1'b0;
            sts_count   <= '0;
            done        <= 1'b0;
        end else begin
            trg_prev    <= trg;
            state       <= state_nxt;
            rdr_aresetn <= (state_nxt == S_RUN);
            sts_busy    <= (state_nxt != S_IDLE);
            done        <= (state_nxt == S_DONE);

            if ((state == S_IDLE) && (state_nxt == S_ARM)) begin
                rdr_cfg   <= cfg_last;
                repeat_q  <= cfg_repeat;
                gap_q     <= cfg_gap;
                sts_count <= '0;
            end else if ((state == S_RUN) && tlast_hs) begin
                sts_count <= count_inc;
            end

            if ((state != S_GAP) && (state_nxt == S_GAP)) begin
                gap_cnt <= gap_q;
            end else if (state == S_GAP) begin
                gap_cnt <= gap_cnt - GAP_WIDTH'(1);
            end
        end
    end

endmodule
